// File: rtl/instr_feeder_pkg.sv
// Shared definitions for the instruction feeder and the processor control unit:
// opcode encodings, instruction field slices and the feeder state encoding.
package instr_feeder_pkg;

    localparam int INSTR_W = 9;

    localparam int CMD_HI = 8;
    localparam int CMD_LO = 6;
    localparam int XXX_HI = 5;
    localparam int XXX_LO = 3;
    localparam int YYY_HI = 2;
    localparam int YYY_LO = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_HALT
    } feed_state_t;

    function automatic logic [2:0] f_cmd(input logic [INSTR_W-1:0] word);
        return word[CMD_HI:CMD_LO];
    endfunction

    function automatic logic [2:0] f_xxx(input logic [INSTR_W-1:0] word);
        return word[XXX_HI:XXX_LO];
    endfunction

    function automatic logic [2:0] f_yyy(input logic [INSTR_W-1:0] word);
        return word[YYY_HI:YYY_LO];
    endfunction

    // mvi is the only two-word instruction; every other opcode waits for one done.
    function automatic logic f_is_mvi(input logic [INSTR_W-1:0] word);
        return f_cmd(word) == OP_MVI;
    endfunction

endpackage

// File: rtl/instr_feeder_prog_mem.sv
// Program store: DEPTH x W register file, synchronous write, two asynchronous
// read ports so an instruction and its immediate can be fetched together.
module instr_feeder_prog_mem #(
    parameter int W     = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [W-1:0]  o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [W-1:0]  o_rdata_b
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/instr_feeder.sv
// Issues a stored program to the processor over the din/run/done handshake,
// supplying mvi immediates and guarding each instruction with a watchdog.
module instr_feeder
    import instr_feeder_pkg::*;
#(
    parameter int W       = 9,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [W-1:0]  load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          done,
    output logic [W-1:0]  din,
    output logic          run,
    output logic          busy,
    output logic          finished,
    output logic          err,
    output logic [AW-1:0] pc
);

    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    feed_state_t  r_state;
    logic [AW:0]  r_pc;
    logic [AW:0]  r_len;
    logic [WDW-1:0] r_wdog;
    logic [W-1:0] r_din;
    logic         r_run;
    logic         r_busy;
    logic         r_fin;
    logic         r_err;
    logic         r_two;

    logic          w_we;
    logic [AW-1:0] w_addr_a;
    logic [AW-1:0] w_addr_b;
    logic [W-1:0]  w_rd_a;
    logic [W-1:0]  w_rd_b;
    logic [AW:0]   w_pc_adv;
    logic          w_adv_halt;
    logic          w_trunc_start;
    logic          w_trunc_adv;
    logic          w_trunc_now;

    // Port A always looks at the word that would be issued next, so the ISSUE
    // cycle can be entered back-to-back with din and run already registered.
    assign w_pc_adv   = r_pc + (r_two ? (AW+1)'(2) : (AW+1)'(1));
    assign w_addr_a   = (r_state == S_IDLE) ? '0 : w_pc_adv[AW-1:0];
    assign w_addr_b   = r_pc[AW-1:0] + AW'(1);
    assign w_we       = load_en && (r_state == S_IDLE);
    assign w_adv_halt = (w_pc_adv >= r_len);

    // An mvi whose immediate lies beyond the program end is never handed out.
    assign w_trunc_start = f_is_mvi(w_rd_a) && (prog_len <= (AW+1)'(1));
    assign w_trunc_adv   = f_is_mvi(w_rd_a) && ((w_pc_adv + (AW+1)'(1)) >= r_len);
    assign w_trunc_now   = r_two && ((r_pc + (AW+1)'(1)) >= r_len);

    instr_feeder_prog_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (load_addr),
        .i_wdata   (load_data),
        .i_raddr_a (w_addr_a),
        .o_rdata_a (w_rd_a),
        .i_raddr_b (w_addr_b),
        .o_rdata_b (w_rd_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_wdog  <= '0;
            r_din   <= '0;
            r_run   <= 1'b0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
            r_err   <= 1'b0;
            r_two   <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            r_run <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start && !load_en) begin
                        r_len  <= prog_len;
                        r_pc   <= '0;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (prog_len == '0) begin
                            r_state <= S_HALT;
                            r_fin   <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_din   <= w_rd_a;
                            r_run   <= !w_trunc_start;
                            r_two   <= f_is_mvi(w_rd_a);
                        end
                    end
                end
                S_ISSUE: begin
                    r_wdog <= '0;
                    if (w_trunc_now) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
                    end else if (r_two) begin
                        r_din   <= w_rd_b;
                        r_state <= S_IMM;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_IMM, S_WAIT: begin
                    if (done) begin
                        if (w_adv_halt) begin
                            r_state <= S_HALT;
                            r_fin   <= !r_err;
                        end else begin
                            r_state <= S_ISSUE;
                            r_pc    <= w_pc_adv;
                            r_din   <= w_rd_a;
                            r_run   <= !w_trunc_adv;
                            r_two   <= f_is_mvi(w_rd_a);
                        end
                    end else if (r_state == S_IMM) begin
                        r_state <= S_WAIT;
                    end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_wdog <= r_wdog + WDW'(1);
                    end
                end
                S_HALT: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign din      = r_din;
    assign run      = r_run;
    assign busy     = r_busy;
    assign finished = r_fin;
    assign err      = r_err;
    assign pc       = r_pc[AW-1:0];

endmodule
